// File: rtl/uart_rx_deserializer_if.sv
// Holding-stage bus between the UART receiver (master) and the consuming core (slave).
interface uart_rx_deserializer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_error;
    logic       frame_error;
    logic       overrun;

    modport master (
        output rx_data, rx_valid, parity_error, frame_error, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_error, frame_error, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversampled start detection, LSB-first 8-bit framing with parity/stop
// checks, and a registered valid/ready holding stage with a sticky overrun flag.
module uart_rx_deserializer #(
    parameter int OVERSAMPLE  = 10,
    parameter int SYNC_STAGES = 2,
    parameter bit PARITY_EN   = 1'b1,
    parameter bit PARITY_ODD  = 1'b0
) (
    input  logic                   physical_clock,
    input  logic                   init_flag,
    input  logic                   sample_tick,
    input  logic                   rx_serial,
    output logic                   busy,
    uart_rx_deserializer_if.master rx_bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rxs_s;
    state_t                 state_r;
    logic [CW-1:0]          cnt_r;
    logic [2:0]             bit_idx_r;
    logic [7:0]             shift_r;
    logic                   perr_r;
    logic                   busy_r;
    logic [7:0]             data_r;
    logic                   valid_r;
    logic                   pe_r;
    logic                   fe_r;
    logic                   ovr_r;
    logic                   commit_s;
    logic                   accept_s;
    logic                   handshake_s;

    // Metastability synchronizer on the asynchronous line; idles high.
    always_ff @(posedge physical_clock) begin
        if (!init_flag) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx_serial};
        end
    end

    assign rxs_s       = sync_r[SYNC_STAGES-1];
    // The stop sample ends the frame; counting to N-1 avoids overflowing cnt at N.
    assign commit_s    = (state_r == ST_STOP) && sample_tick && (cnt_r == CNT_LAST);
    assign handshake_s = valid_r && rx_bus.rx_ready;
    assign accept_s    = !valid_r || rx_bus.rx_ready;

    // Frame FSM: advances only on sample ticks, samples each bit at its midpoint.
    always_ff @(posedge physical_clock) begin
        if (!init_flag) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            perr_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else if (sample_tick) begin
            case (state_r)
                ST_IDLE: begin
                    if (!rxs_s) begin
                        state_r <= ST_START;
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_r == CNT_MID) begin
                        cnt_r <= {CW{1'b0}};
                        if (!rxs_s) begin
                            state_r   <= ST_DATA;
                            bit_idx_r <= 3'd0;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r     <= {CW{1'b0}};
                        shift_r   <= {rxs_s, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= PARITY_EN ? ST_PARITY : ST_STOP;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_PARITY: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= {CW{1'b0}};
                        perr_r  <= parity8(shift_r) ^ rxs_s ^ PARITY_ODD;
                        state_r <= ST_STOP;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CW{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Holding register: commit, consume and sticky overrun bookkeeping.
    always_ff @(posedge physical_clock) begin
        if (!init_flag) begin
            data_r  <= 8'h00;
            valid_r <= 1'b0;
            pe_r    <= 1'b0;
            fe_r    <= 1'b0;
            ovr_r   <= 1'b0;
        end else begin
            if (commit_s && accept_s) begin
                data_r  <= shift_r;
                pe_r    <= PARITY_EN ? perr_r : 1'b0;
                fe_r    <= ~rxs_s;
                valid_r <= 1'b1;
            end else if (handshake_s) begin
                valid_r <= 1'b0;
            end
            // A handshake always wins, even when it coincides with a commit.
            if (handshake_s) begin
                ovr_r <= 1'b0;
            end else if (commit_s && !accept_s) begin
                ovr_r <= 1'b1;
            end
        end
    end

    assign rx_bus.rx_data      = data_r;
    assign rx_bus.rx_valid     = valid_r;
    assign rx_bus.parity_error = pe_r;
    assign rx_bus.frame_error  = fe_r;
    assign rx_bus.overrun      = ovr_r;
    assign busy                = busy_r;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: an even-parity and an odd-parity instance share one serial
// line; every handshake is recorded and compared against frame-level expectations.
module tb_uart_rx_deserializer;
    localparam int N = 10;

    logic physical_clock = 1'b0;
    logic init_flag      = 1'b0;
    logic sample_tick    = 1'b1;
    logic rx_serial      = 1'b1;
    logic rx_ready       = 1'b1;
    logic busy_even;
    logic busy_odd;
    bit   tick_rand      = 1'b0;

    uart_rx_deserializer_if bus_even ();
    uart_rx_deserializer_if bus_odd ();
    assign bus_even.rx_ready = rx_ready;
    assign bus_odd.rx_ready  = rx_ready;

    uart_rx_deserializer #(.OVERSAMPLE(N), .SYNC_STAGES(2), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut (
        .physical_clock(physical_clock), .init_flag(init_flag), .sample_tick(sample_tick),
        .rx_serial(rx_serial), .busy(busy_even), .rx_bus(bus_even));

    uart_rx_deserializer #(.OVERSAMPLE(N), .SYNC_STAGES(2), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_odd (
        .physical_clock(physical_clock), .init_flag(init_flag), .sample_tick(sample_tick),
        .rx_serial(rx_serial), .busy(busy_odd), .rx_bus(bus_odd));

    always #5 physical_clock = ~physical_clock;

    always @(negedge physical_clock)
        sample_tick = tick_rand ? ($urandom_range(0, 2) == 0) : 1'b1;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       perr_odd;
        logic [7:0] data_odd;
    } xfer_t;

    xfer_t obs_mem [0:255];
    xfer_t exp_mem [0:255];
    int obs_wr = 0, obs_rd = 0, exp_wr = 0, exp_rd = 0;
    int vec_cnt = 0, err_cnt = 0;

    // Record every handshake that will happen at the next rising edge.
    always @(negedge physical_clock)
        if (bus_even.rx_valid && rx_ready && obs_wr < 256) begin
            obs_mem[obs_wr] = {bus_even.rx_data, bus_even.parity_error, bus_even.frame_error,
                               bus_odd.parity_error, bus_odd.rx_data};
            obs_wr = obs_wr + 1;
        end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input logic pe_even, input logic fe);
        exp_mem[exp_wr] = {d, pe_even, fe, ~pe_even, d};
        exp_wr++;
    endtask

    task automatic drain(input int budget);
        int cyc = 0;
        while (obs_wr < exp_wr && cyc < budget) begin
            @(negedge physical_clock);
            cyc++;
        end
        check("xfer_count", 32'(obs_wr), 32'(exp_wr));
        while (obs_rd < obs_wr && exp_rd < exp_wr) begin
            check("xfer_frame", 32'(obs_mem[obs_rd]), 32'(exp_mem[exp_rd]));
            obs_rd++;
            exp_rd++;
        end
        obs_rd = obs_wr;
        exp_rd = exp_wr;
    endtask

    task automatic hold_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge physical_clock);
            if (sample_tick) k++;
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int gap);
        rx_serial = 1'b0;
        hold_ticks(N);
        for (int i = 0; i < 8; i++) begin
            rx_serial = d[i];
            hold_ticks(N);
        end
        rx_serial = par;
        hold_ticks(N);
        rx_serial = stp;
        hold_ticks(N);
        rx_serial = 1'b1;
        if (gap > 0) hold_ticks(gap);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       par;
        logic       stp;
        int         gap;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int lat;
        int base;
        logic [7:0] rd;
        logic rp;

        tbl[0] = '{8'h3C, 1'b1, 1'b0, 2 * N, 8'h3C, 1'b1, 1'b1};
        tbl[1] = '{8'hA5, 1'b0, 1'b1, 0,     8'hA5, 1'b0, 1'b0};
        tbl[2] = '{8'hFF, 1'b0, 1'b1, 0,     8'hFF, 1'b0, 1'b0};
        tbl[3] = '{8'h01, 1'b0, 1'b1, 0,     8'h01, 1'b1, 1'b0};
        tbl[4] = '{8'hC3, 1'b0, 1'b0, 2 * N, 8'hC3, 1'b0, 1'b1};
        tbl[5] = '{8'h80, 1'b1, 1'b1, 0,     8'h80, 1'b0, 1'b0};
        tbl[6] = '{8'h00, 1'b1, 1'b1, 0,     8'h00, 1'b1, 1'b0};
        tbl[7] = '{8'h96, 1'b0, 1'b1, N,     8'h96, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge physical_clock);
        #1 init_flag = 1'b1;
        check("rst_data",    32'(bus_even.rx_data), 32'h00);
        check("rst_valid",   32'(bus_even.rx_valid), 32'h0);
        check("rst_perr",    32'(bus_even.parity_error), 32'h0);
        check("rst_ferr",    32'(bus_even.frame_error), 32'h0);
        check("rst_overrun", 32'(bus_even.overrun), 32'h0);
        check("rst_busy",    32'(busy_even), 32'h0);

        // Basic byte with latency measurement
        push_exp(8'hA5, 1'b0, 1'b0);
        fork
            send_frame(8'hA5, 1'b0, 1'b1, N);
            begin
                @(posedge physical_clock);
                #1 lat = 0;
                while (!bus_even.rx_valid && lat < 200) begin
                    @(posedge physical_clock);
                    lat++;
                    #1;
                end
                check("valid_latency", 32'(lat), 32'd107);
                @(posedge physical_clock);
                #1 check("valid_one_cycle", 32'(bus_even.rx_valid), 32'h0);
            end
        join
        drain(300);

        // Table of frames, back to back where the stop bit is good
        for (int i = 0; i < 8; i++) begin
            push_exp(tbl[i].exp_d, tbl[i].exp_pe, tbl[i].exp_fe);
            send_frame(tbl[i].d, tbl[i].par, tbl[i].stp, tbl[i].gap);
        end
        drain(300);

        // Glitch rejection
        base = obs_wr;
        rx_serial = 1'b0;
        hold_ticks(3);
        rx_serial = 1'b1;
        check("glitch_busy_rise", 32'(busy_even), 32'h1);
        hold_ticks(5);
        check("glitch_busy_fall", 32'(busy_even), 32'h0);
        hold_ticks(40);
        check("glitch_no_xfer", 32'(obs_wr), 32'(base));
        check("glitch_valid",   32'(bus_even.rx_valid), 32'h0);
        check("glitch_flags",   32'({bus_even.parity_error, bus_even.frame_error, bus_even.overrun}), 32'h0);

        // Overrun then single-cycle consume
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 0);
        send_frame(8'h22, 1'b0, 1'b1, 5);
        check("ovr_data",    32'(bus_even.rx_data), 32'h11);
        check("ovr_valid",   32'(bus_even.rx_valid), 32'h1);
        check("ovr_flag",    32'(bus_even.overrun), 32'h1);
        check("ovr_flag_odd", 32'(bus_odd.overrun), 32'h1);
        push_exp(8'h11, 1'b0, 1'b0);
        rx_ready = 1'b1;
        @(posedge physical_clock);
        #1 rx_ready = 1'b0;
        check("ovr_consume_valid", 32'(bus_even.rx_valid), 32'h0);
        check("ovr_consume_clear", 32'(bus_even.overrun), 32'h0);
        drain(10);

        // Commit and consume in the same cycle while overrun is set
        send_frame(8'h11, 1'b0, 1'b1, 0);
        send_frame(8'h33, 1'b0, 1'b1, 0);
        push_exp(8'h11, 1'b0, 1'b0);
        fork
            send_frame(8'h22, 1'b0, 1'b1, 5);
            begin
                @(posedge physical_clock);
                repeat (106) @(posedge physical_clock);
                #1 check("sim_pre_overrun", 32'(bus_even.overrun), 32'h1);
                check("sim_pre_data", 32'(bus_even.rx_data), 32'h11);
                rx_ready = 1'b1;
                @(posedge physical_clock);
                #1 rx_ready = 1'b0;
            end
        join
        check("sim_data",    32'(bus_even.rx_data), 32'h22);
        check("sim_valid",   32'(bus_even.rx_valid), 32'h1);
        check("sim_overrun", 32'(bus_even.overrun), 32'h0);
        push_exp(8'h22, 1'b0, 1'b0);
        rx_ready = 1'b1;
        @(posedge physical_clock);
        #1 rx_ready = 1'b0;
        drain(10);

        // Reset during data bit 4, then a clean frame
        rx_ready = 1'b1;
        fork
            send_frame(8'hF0, 1'b1, 1'b1, 2 * N);
            begin
                repeat (55) @(posedge physical_clock);
                #1 check("midrst_busy_before", 32'(busy_even), 32'h1);
                init_flag = 1'b0;
                @(posedge physical_clock);
                #1 init_flag = 1'b1;
                check("midrst_outputs", 32'({bus_even.rx_data, bus_even.rx_valid, bus_even.parity_error,
                                              bus_even.frame_error, bus_even.overrun, busy_even}), 32'h0);
            end
        join
        push_exp(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, N);
        drain(300);

        // Randomized frames with gated sample ticks against the frame-level model
        tick_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rd = 8'($urandom);
            rp = 1'($urandom_range(0, 1));
            push_exp(rd, (^rd) ^ rp, 1'b0);
            send_frame(rd, rp, 1'b1, $urandom_range(0, 3));
        end
        drain(2000);
        check("rand_no_overrun", 32'({bus_even.overrun, bus_odd.overrun}), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
